// File: rtl/debounce_pkg.sv
// Shared definitions for the two-channel button debouncer: the per-channel
// FSM state encoding and the default number of stable samples required.
package debounce_pkg;

    // Default number of consecutive stable synchronized samples needed
    // before a level change is accepted (legal range 2..255).
    localparam int DEBOUNCE_CYCLES_DEFAULT = 4;

    // Per-channel debounce FSM states.
    //   STABLE_LOW  : output is 0 and the input agrees
    //   CHK_HIGH    : output is 0, input has gone high, counting samples
    //   STABLE_HIGH : output is 1 and the input agrees
    //   CHK_LOW     : output is 1, input has gone low, counting samples
    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        CHK_HIGH    = 2'd1,
        STABLE_HIGH = 2'd2,
        CHK_LOW     = 2'd3
    } db_state_t;

    // Width of the stable-sample counter for a given debounce length.
    function automatic int db_cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage : debounce_pkg

// File: rtl/debounce_channel.sv
// One debounce channel: a 2-flop synchronizer followed by a four-state FSM
// that only accepts a new level after DEBOUNCE_CYCLES consecutive agreeing
// synchronized samples. Any reversal during a check discards the count.
// The accepted level and its rise/fall pulses are all registered so the
// pulse is high exactly in the cycle where o_level first shows the new value.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic            r_sync1;
    logic            r_sync2;
    db_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic            r_level;
    logic            r_rise;
    logic            r_fall;

    db_state_t       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic            w_level_nxt;
    logic            w_rise_nxt;
    logic            w_fall_nxt;

    // Two-flop synchronizer bringing the asynchronous sensor level into clk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Next-state logic: count agreeing samples, accept on the last one,
    // and fall back to the stable state (count cleared) on any reversal.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_level_nxt = r_level;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;

        case (r_state)
            STABLE_LOW: begin
                if (r_sync2) begin
                    w_state_nxt = CHK_HIGH;
                    w_cnt_nxt   = CNT_ONE;
                end else begin
                    w_cnt_nxt   = CNT_ZERO;
                end
            end

            CHK_HIGH: begin
                if (r_sync2) begin
                    if (r_cnt == CNT_LAST) begin
                        w_state_nxt = STABLE_HIGH;
                        w_cnt_nxt   = CNT_ZERO;
                        w_level_nxt = 1'b1;
                        w_rise_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt   = r_cnt + CNT_ONE;
                    end
                end else begin
                    w_state_nxt = STABLE_LOW;
                    w_cnt_nxt   = CNT_ZERO;
                end
            end

            STABLE_HIGH: begin
                if (!r_sync2) begin
                    w_state_nxt = CHK_LOW;
                    w_cnt_nxt   = CNT_ONE;
                end else begin
                    w_cnt_nxt   = CNT_ZERO;
                end
            end

            CHK_LOW: begin
                if (!r_sync2) begin
                    if (r_cnt == CNT_LAST) begin
                        w_state_nxt = STABLE_LOW;
                        w_cnt_nxt   = CNT_ZERO;
                        w_level_nxt = 1'b0;
                        w_fall_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt   = r_cnt + CNT_ONE;
                    end
                end else begin
                    w_state_nxt = STABLE_HIGH;
                    w_cnt_nxt   = CNT_ZERO;
                end
            end

            default: begin
                w_state_nxt = STABLE_LOW;
                w_cnt_nxt   = CNT_ZERO;
                w_level_nxt = 1'b0;
            end
        endcase
    end

    // FSM, counter, accepted level and edge pulses, all cleared by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= STABLE_LOW;
            r_cnt   <= CNT_ZERO;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule : debounce_channel

// File: rtl/btn_debounce.sv
// Two-channel button debouncer for a quadrature-style sensor pair {b, a}.
// Each bit runs through its own independent debounce_channel, so changes on
// both inputs at once are accepted in the same cycle. The FSM state of each
// channel is visible through the hierarchy (u_ch_a.r_state, u_ch_b.r_state).
module btn_debounce
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] btn_raw,
    output logic [1:0] btn,
    output logic [1:0] btn_rise,
    output logic [1:0] btn_fall
);

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch_a (
        .clk     (clk),
        .reset   (reset),
        .i_raw   (btn_raw[0]),
        .o_level (btn[0]),
        .o_rise  (btn_rise[0]),
        .o_fall  (btn_fall[0])
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch_b (
        .clk     (clk),
        .reset   (reset),
        .i_raw   (btn_raw[1]),
        .o_level (btn[1]),
        .o_rise  (btn_rise[1]),
        .o_fall  (btn_fall[1])
    );

endmodule : btn_debounce

// File: tb/tb_btn_debounce.sv
// Directed testbench for btn_debounce with DEBOUNCE_CYCLES=4. Inputs are
// driven and outputs sampled on the falling clock edge; "tick k" means the
// sample taken after the k-th rising edge following an input change.
module tb_btn_debounce;

    logic       clk;
    logic       reset;
    logic [1:0] btn_raw;
    logic [1:0] btn;
    logic [1:0] btn_rise;
    logic [1:0] btn_fall;

    int total;
    int bad;

    btn_debounce #(
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_raw  (btn_raw),
        .btn      (btn),
        .btn_rise (btn_rise),
        .btn_fall (btn_fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one full clock: exactly one rising edge passes.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        btn_raw = 2'b00;
        tick();
        tick();
        total++;
        if (btn !== 2'b00) begin
            bad++;
            $display("[TB] FAIL reset_btn: got %b want 00", btn);
        end
        total++;
        if ({btn_rise, btn_fall} !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL reset_pulses: rise=%b fall=%b want 00/00", btn_rise, btn_fall);
        end
        reset = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            total++;
            if ({btn, btn_rise, btn_fall} !== 6'b000000) begin
                bad++;
                $display("[TB] FAIL idle_low tick%0d: btn=%b rise=%b fall=%b want 00/00/00",
                         k, btn, btn_rise, btn_fall);
            end
        end
    endtask

    task automatic test_rise_fall_ch0();
        btn_raw = 2'b01;
        for (int k = 1; k <= 7; k++) begin
            tick();
            total++;
            if (k < 6) begin
                if ({btn, btn_rise} !== 4'b0000) begin
                    bad++;
                    $display("[TB] FAIL rise0_early tick%0d: btn=%b rise=%b want 00/00", k, btn, btn_rise);
                end
            end else if (k == 6) begin
                if ({btn, btn_rise, btn_fall} !== 6'b010100) begin
                    bad++;
                    $display("[TB] FAIL rise0_edge tick6: btn=%b rise=%b fall=%b want 01/01/00",
                             btn, btn_rise, btn_fall);
                end
            end else begin
                if ({btn, btn_rise} !== 4'b0100) begin
                    bad++;
                    $display("[TB] FAIL rise0_after tick7: btn=%b rise=%b want 01/00", btn, btn_rise);
                end
            end
        end
        btn_raw = 2'b00;
        for (int k = 1; k <= 7; k++) begin
            tick();
            total++;
            if (k < 6) begin
                if ({btn, btn_fall} !== 4'b0100) begin
                    bad++;
                    $display("[TB] FAIL fall0_early tick%0d: btn=%b fall=%b want 01/00", k, btn, btn_fall);
                end
            end else if (k == 6) begin
                if ({btn, btn_rise, btn_fall} !== 6'b000001) begin
                    bad++;
                    $display("[TB] FAIL fall0_edge tick6: btn=%b rise=%b fall=%b want 00/00/01",
                             btn, btn_rise, btn_fall);
                end
            end else begin
                if ({btn, btn_fall} !== 4'b0000) begin
                    bad++;
                    $display("[TB] FAIL fall0_after tick7: btn=%b fall=%b want 00/00", btn, btn_fall);
                end
            end
        end
    endtask

    task automatic test_short_pulse();
        btn_raw = 2'b01;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k == 3) btn_raw = 2'b00;
            total++;
            if ({btn, btn_rise, btn_fall} !== 6'b000000) begin
                bad++;
                $display("[TB] FAIL short_pulse tick%0d: btn=%b rise=%b fall=%b want 00/00/00",
                         k, btn, btn_rise, btn_fall);
            end
        end
    endtask

    task automatic test_bounce_ch1();
        int riseCount;
        riseCount = 0;
        for (int i = 0; i < 4; i++) begin
            btn_raw[1] = (i % 2 == 0);
            tick();
            if (btn_rise[1]) riseCount++;
            total++;
            if (btn !== 2'b00) begin
                bad++;
                $display("[TB] FAIL bounce_hold step%0d: btn=%b want 00", i, btn);
            end
        end
        btn_raw[1] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (btn_rise[1]) riseCount++;
            total++;
            if (k < 6) begin
                if (btn !== 2'b00) begin
                    bad++;
                    $display("[TB] FAIL bounce_early tick%0d: btn=%b want 00", k, btn);
                end
            end else if (k == 6) begin
                if ({btn, btn_rise} !== 4'b1010) begin
                    bad++;
                    $display("[TB] FAIL bounce_edge tick6: btn=%b rise=%b want 10/10", btn, btn_rise);
                end
            end else begin
                if ({btn, btn_rise} !== 4'b1000) begin
                    bad++;
                    $display("[TB] FAIL bounce_after tick%0d: btn=%b rise=%b want 10/00", k, btn, btn_rise);
                end
            end
        end
        total++;
        if (riseCount !== 1) begin
            bad++;
            $display("[TB] FAIL bounce_rise_count: got %0d want 1", riseCount);
        end
        btn_raw = 2'b00;
        repeat (8) tick();
        total++;
        if (btn !== 2'b00) begin
            bad++;
            $display("[TB] FAIL bounce_cleanup: btn=%b want 00", btn);
        end
    endtask

    task automatic test_both_channels();
        btn_raw = 2'b11;
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (k == 2) btn_raw[1] = 1'b0;
            if (k == 4) btn_raw[1] = 1'b1;
            total++;
            if (k < 6) begin
                if (btn !== 2'b00) begin
                    bad++;
                    $display("[TB] FAIL both_early tick%0d: btn=%b want 00", k, btn);
                end
            end else if (k == 6) begin
                if ({btn, btn_rise} !== 4'b0101) begin
                    bad++;
                    $display("[TB] FAIL both_ch0_edge tick6: btn=%b rise=%b want 01/01", btn, btn_rise);
                end
            end else if (k < 10) begin
                if ({btn, btn_rise} !== 4'b0100) begin
                    bad++;
                    $display("[TB] FAIL both_ch1_wait tick%0d: btn=%b rise=%b want 01/00", k, btn, btn_rise);
                end
            end else if (k == 10) begin
                if ({btn, btn_rise} !== 4'b1110) begin
                    bad++;
                    $display("[TB] FAIL both_ch1_edge tick10: btn=%b rise=%b want 11/10", btn, btn_rise);
                end
            end else begin
                if ({btn, btn_rise} !== 4'b1100) begin
                    bad++;
                    $display("[TB] FAIL both_after tick11: btn=%b rise=%b want 11/00", btn, btn_rise);
                end
            end
        end
        btn_raw = 2'b00;
        for (int k = 1; k <= 6; k++) begin
            tick();
            total++;
            if (k < 6) begin
                if ({btn, btn_fall} !== 4'b1100) begin
                    bad++;
                    $display("[TB] FAIL both_fall_early tick%0d: btn=%b fall=%b want 11/00", k, btn, btn_fall);
                end
            end else begin
                if ({btn, btn_rise, btn_fall} !== 6'b000011) begin
                    bad++;
                    $display("[TB] FAIL both_fall_edge tick6: btn=%b rise=%b fall=%b want 00/00/11",
                             btn, btn_rise, btn_fall);
                end
            end
        end
        tick();
    endtask

    task automatic test_reset_mid_check();
        int riseCount;
        riseCount = 0;
        btn_raw = 2'b10;
        repeat (8) tick();
        total++;
        if (btn !== 2'b10) begin
            bad++;
            $display("[TB] FAIL midreset_setup: btn=%b want 10", btn);
        end
        btn_raw = 2'b11;
        repeat (4) tick();
        #2;
        reset = 1'b0;
        #1;
        total++;
        if ({btn, btn_rise, btn_fall} !== 6'b000000) begin
            bad++;
            $display("[TB] FAIL midreset_async: btn=%b rise=%b fall=%b want 00/00/00",
                     btn, btn_rise, btn_fall);
        end
        tick();
        tick();
        reset = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (btn_rise[0]) riseCount++;
            total++;
            if (k < 6) begin
                if ({btn, btn_rise, btn_fall} !== 6'b000000) begin
                    bad++;
                    $display("[TB] FAIL midreset_early tick%0d: btn=%b rise=%b fall=%b want 00/00/00",
                             k, btn, btn_rise, btn_fall);
                end
            end else if (k == 6) begin
                if ({btn, btn_rise, btn_fall} !== 6'b111100) begin
                    bad++;
                    $display("[TB] FAIL midreset_edge tick6: btn=%b rise=%b fall=%b want 11/11/00",
                             btn, btn_rise, btn_fall);
                end
            end else begin
                if ({btn, btn_rise} !== 4'b1100) begin
                    bad++;
                    $display("[TB] FAIL midreset_after tick%0d: btn=%b rise=%b want 11/00", k, btn, btn_rise);
                end
            end
        end
        total++;
        if (riseCount !== 1) begin
            bad++;
            $display("[TB] FAIL midreset_rise_count: got %0d want 1", riseCount);
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b0;
        btn_raw = 2'b00;
        @(negedge clk);
        test_reset();
        test_rise_fall_ch0();
        test_short_pulse();
        test_bounce_ch1();
        test_both_channels();
        test_reset_mid_check();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule : tb_btn_debounce

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning the number of consecutive stable synchronized samples needed to accept a level change; legal range 2..255.
REQ-002 The block SHALL have port clk, input, 1, the single clock for all state.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port btn_raw, input, 2, the raw asynchronous sensor levels {b, a}.
REQ-005 The block SHALL have port btn, output, 2, the debounced levels {b, a}, feeding the counter's btn input directly.
REQ-006 The block SHALL have port btn_rise, output, 2, a one-cycle pulse per channel when btn goes 0->1.
REQ-007 The block SHALL have port btn_fall, output, 2, a one-cycle pulse per channel when btn goes 1->0.

Function
REQ-008 Each channel SHALL pass btn_raw through a 2-flop synchronizer; only the second flop output (sync) feeds the FSM.
REQ-009 Each channel SHALL run an independent FSM with states STABLE_LOW, CHK_HIGH, STABLE_HIGH and CHK_LOW, plus a stable-sample counter cnt.
REQ-010 In STABLE_LOW with sync=1, the FSM SHALL go to CHK_HIGH with cnt=1; with sync=0 it SHALL stay, cnt=0.
REQ-011 In CHK_HIGH with sync=1 and cnt<DEBOUNCE_CYCLES-1, the FSM SHALL increment cnt; with sync=1 and cnt=DEBOUNCE_CYCLES-1, it SHALL go to STABLE_HIGH, cnt=0, set btn=1 and pulse btn_rise.
REQ-012 In CHK_HIGH with sync=0, the FSM SHALL return to STABLE_LOW, cnt=0, with btn unchanged and no pulse.
REQ-013 STABLE_HIGH/CHK_LOW SHALL mirror REQ-010..012 with polarity inverted, setting btn=0 and pulsing btn_fall.
REQ-014 Latency from a btn_raw change, held stable, to the btn change SHALL be exactly 2+DEBOUNCE_CYCLES clk edges, counting the first edge that samples the new value as edge 1.
REQ-015 btn_rise and btn_fall SHALL be registered, high for exactly the cycle in which btn first shows its new value, and never both high on one channel.
REQ-016 cnt SHALL be $clog2(DEBOUNCE_CYCLES+1) bits wide and SHALL never exceed DEBOUNCE_CYCLES-1 (no wrap).
REQ-017 Any sync reversal before acceptance SHALL discard all accumulated count; partial counts SHALL NOT carry over.
REQ-018 The channels SHALL be fully independent; simultaneous changes on both SHALL produce btn updates in the same cycle.

Reset
REQ-019 While reset=0, all sync flops, cnt, btn, btn_rise and btn_fall SHALL be 0 and the FSM SHALL be STABLE_LOW, asynchronously.
REQ-020 After reset release with btn_raw held 1, btn SHALL rise exactly 2+DEBOUNCE_CYCLES edges after the first post-release edge (REQ-014).
REQ-021 Reset asserted mid-check SHALL abandon the check, and no pulse SHALL be emitted on release.

Structure
REQ-022 Package debounce_pkg SHALL hold the FSM state enum typedef (db_state_t) and DEBOUNCE_CYCLES_DEFAULT=4.
REQ-023 Per-channel logic (synchronizer, FSM, counter, pulses) SHALL be sub-module debounce_channel, instantiated twice by btn_debounce.
REQ-024 Each FSM state SHALL be exposable for debug through hierarchy only; no extra ports.

Verification (DEBOUNCE_CYCLES=4)
REQ-025 The bench SHALL cover reset, then btn_raw=00 for 20 cycles -> btn=00, btn_rise=btn_fall=00 throughout.
REQ-026 The bench SHALL cover btn_raw[0] 0->1 and held -> btn[0]=1 and btn_rise[0]=1 exactly 6 edges after the change, with btn_rise[0]=0 the next cycle.
REQ-027 The bench SHALL cover btn_raw[0] high for 3 cycles, then low -> btn[0] stays 0 with no pulses.
REQ-028 The bench SHALL cover btn_raw[1] bouncing 1,0,1,0,1 (one cycle each), then held 1 -> btn[1] rises 6 edges after the final 0->1, with exactly one btn_rise[1] pulse.
REQ-029 The bench SHALL cover both channels 0->1 in the same cycle, with a 2-cycle glitch on channel 1 during channel 0's check -> btn[0] rises on schedule and btn[1] is unaffected until its own 6-edge window completes.
REQ-030 The bench SHALL cover reset asserted 2 cycles into CHK_HIGH with btn_raw[0]=1 -> btn=00 immediately; after release btn[0] rises exactly 6 edges later with one pulse.
